serial_chunk_subtractor: RTL and testbench
==========================================

# serial_chunk_subtractor

Multi-cycle fixed-point subtractor computing d = a − b − borrow_in on N-bit operands, W bits per clock, with valid/ready handshakes on both sides. It is the subtract-direction counterpart to the structural adders in the FixedPointArithmetic Add unit. It serves datapaths that trade latency for area. Each cycle reuses one W-bit chunk datapath: a + ~b + carry, where carry = ~borrow.

## Interface
Parameters:
- N, 32, operand/result width; must be a multiple of W
- W, 8, bits processed per cycle; 1 ≤ W ≤ N

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  N  minuend, unsigned or two's complement
- b  input  N  subtrahend
- borrow_in  input  1  incoming borrow
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- d  output  N  difference, a − b − borrow_in mod 2^N
- borrow_out  output  1  1 iff unsigned a < b + borrow_in
- overflow  output  1  signed overflow of a − b − borrow_in

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b and carry = ~borrow_in, clear the chunk counter, go to BUSY.
- BUSY:
  - Each cycle, chunk k (bits k·W+W−1 : k·W) computes sum = a_k + ~b_k + carry.
  - Write the W sum bits into result chunk k and register the chunk carry-out as the next carry.
  - Increment k. After chunk N/W−1, go to DONE.
- DONE:
  - out_valid = 1.
  - borrow_out = ~final carry.
  - overflow = (a[N−1] ≠ b[N−1]) & (d[N−1] ≠ a[N−1]), taken from the latched operands.
  - On out_valid & out_ready, go to IDLE.
- Input handling:
  - in_ready = (state == IDLE) only; there is no accept in the same cycle as result handoff.
  - Inputs are ignored unless accepted.
  - Latched operands are immune to input changes during BUSY and DONE.
- Output stability:
  - d, borrow_out and overflow hold stable while out_valid = 1 and out_ready = 0.
  - They hold the last result after handoff until the next result is written.
- Reset values: in_ready = 1 after reset deasserts; out_valid = 0, d = 0, borrow_out = 0, overflow = 0.
- Reset mid-operation (BUSY or DONE): the operation is abandoned, all state and outputs return to their reset values, and no out_valid is produced.
- Chunk counter: width $clog2(N/W), minimum 1. It does not wrap; the transition to DONE is taken at N/W−1.

## Timing
- Accept edge is cycle 0. BUSY occupies cycles 1 … N/W. out_valid rises on the edge ending cycle N/W and is seen in cycle N/W+1.
  - Latency from accept to out_valid is N/W+1 cycles; with N = 32, W = 8 this is 5.
- With out_ready held high:
  - DONE lasts 1 cycle.
  - in_ready is seen the cycle after handoff.
  - Throughput is one operation per N/W+2 cycles.
- W = N degenerates to a single BUSY cycle; latency is 2.
- Handshake signals have no combinational path from input to output: in_ready and out_valid are decoded from registered state only.

## Configuration
- Macro: SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN.
- Defined: overflow is computed as specified and registered with d in DONE.
- Undefined:
  - overflow is tied to 0 and no overflow logic or sign-bit registers are built.
  - All other behaviour is identical.

## Structure
- Shared package fixed_point_pkg holds:
  - sub_state_e enum (IDLE, BUSY, DONE)
  - localparam helper for chunk count N/W
  - the elaboration check N % W == 0, which raises $error if violated
- One sub-module, chunk_adder_w: a combinational W-bit adder with inputs x, y, cin and outputs s, cout.
  - It is instantiated once with y = ~b_k.
  - The top level holds the FSM, counter, operand/result registers and handshake logic.

## Test plan
All scenarios use N = 32, W = 8 and the macro defined unless noted.
1. a = 0x00000005, b = 0x00000003, borrow_in = 0 → d = 0x00000002, borrow_out = 0, overflow = 0; out_valid is seen 5 cycles after accept.
2. a = 0x00000000, b = 0x00000001, borrow_in = 0 → d = 0xFFFFFFFF, borrow_out = 1, overflow = 0. Also a = 5, b = 5, borrow_in = 1 → d = 0xFFFFFFFF, borrow_out = 1.
3. a = 0x80000000, b = 0x00000001 → d = 0x7FFFFFFF, borrow_out = 0, overflow = 1. With the macro undefined, overflow stays 0 and d is unchanged.
4. Backpressure: hold out_ready = 0 for 3 cycles in DONE, then 1.
   - d, borrow_out and overflow stay constant; in_ready stays 0.
   - Handoff occurs in exactly one cycle; in_ready = 1 the next cycle.
5. Input isolation: change a, b and in_valid every cycle during BUSY → the result matches the operands latched at accept.
6. Reset mid-operation: assert rst in BUSY cycle 2, then run a new op with a = 0x10, b = 0x01.
   - The next cycle shows out_valid = 0, in_ready = 1 and all outputs 0.
   - The new op returns d = 0x0000000F with no residue from the abandoned one.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the serial chunk subtractor.
// The overflow feature is selected in the top by SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Number of W-bit chunks making up an N-bit operand.
    function automatic int chunk_count(input int n, input int w);
        return n / w;
    endfunction

    // Legal geometry: 1 <= W <= N and W divides N exactly.
    function automatic bit chunk_fit(input int n, input int w);
        return (w >= 1) && (w <= n) && ((n % w) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder_w.sv
// Combinational W-bit adder with carry in/out; one chunk of the serial datapath.
module chunk_adder_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_chunk_subtractor.sv
// Multi-cycle N-bit subtractor, d = a - b - borrow_in, one W-bit chunk per clock.
// Subtraction is done as a + ~b + carry with carry = ~borrow.
// Optional: define SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN to build the signed overflow flag;
// otherwise overflow is tied low.
module serial_chunk_subtractor
    import fixed_point_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int NCH = chunk_count(N, W);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    // Elaboration guard on the chunk geometry
    if (!chunk_fit(N, W)) begin : g_bad_geometry
        $error("serial_chunk_subtractor: N must be a multiple of W with 1 <= W <= N");
    end

    sub_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  res_q, res_d;     // result being assembled during BUSY
    logic [N-1:0]  dout_q, dout_d;   // published result, only updated on entry to DONE
    logic          bo_q, bo_d;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
    logic          ovf_q, ovf_d;
`endif

    logic [W-1:0]  a_k, b_k, sum_k;
    logic          cout_k;

    // Select the current chunk of the latched operands
    always_comb begin
        a_k = a_q[int'(cnt_q)*W +: W];
        b_k = b_q[int'(cnt_q)*W +: W];
    end

    chunk_adder_w #(.W(W)) u_chunk (
        .x    (a_k),
        .y    (~b_k),
        .cin  (carry_q),
        .s    (sum_k),
        .cout (cout_k)
    );

    // Next-state, datapath updates and result publication
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        dout_d  = dout_q;
        bo_d    = bo_q;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~borrow_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d[int'(cnt_q)*W +: W] = sum_k;
                carry_d = cout_k;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    dout_d  = res_d;
                    bo_d    = ~cout_k;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
                    ovf_d   = (a_q[N-1] ^ b_q[N-1]) & (res_d[N-1] ^ a_q[N-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            dout_q  <= '0;
            bo_q    <= 1'b0;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            bo_q    <= bo_d;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign d          = dout_q;
    assign borrow_out = bo_q;
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
    assign overflow   = ovf_q;
`else
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_chunk_subtractor.sv
// Self-checking bench for serial_chunk_subtractor (N=32, W=8).
module tb_serial_chunk_subtractor;

    localparam int N   = 32;
    localparam int W   = 8;
    localparam int LAT = N / W + 1;
    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         borrow_out;
    logic         overflow;

    typedef struct {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    serial_chunk_subtractor #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d          (d),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference: unsigned borrow from an (N+1)-bit difference, signed overflow
    // from an (N+2)-bit signed difference leaving the N-bit range.
    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin);
        exp_t e;
        logic [N:0]          u;
        logic signed [N+1:0] s;
        u = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
        s = $signed({ma[N-1], ma[N-1], ma}) - $signed({mb[N-1], mb[N-1], mb})
            - $signed({{(N+1){1'b0}}, mbin});
        e.d  = u[N-1:0];
        e.bo = u[N];
`ifdef SERIAL_CHUNK_SUBTRACTOR_OVERFLOW_EN
        e.ov = (s[N+1:N-1] != 3'b000) && (s[N+1:N-1] != 3'b111);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    // Present one operation and hold in_valid for its accept edge; optionally score it.
    task automatic send(input logic [N-1:0] sa, input logic [N-1:0] sb, input logic sbin, input bit push);
        int n = 0;
        while (!in_ready && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_wait_in_ready: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end
        a = sa; b = sb; borrow_in = sbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) q.push_back(model(sa, sb, sbin));
    endtask

    // Step until out_valid is seen or the budget runs out; returns cycles stepped.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
        end
        total++;
        if (d !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: d=%h bo=%0b ov=%0b, want 0/0/0", d, borrow_out, overflow);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] ta [3] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        logic [N-1:0] tb [3] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0005};
        logic         tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [N-1:0] td [3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic         tbo[3] = '{1'b0, 1'b1, 1'b1};
        int cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb[i], tc[i], 1'b1);
            wait_out(cyc);
            total++;
            if (!out_valid) begin
                bad++;
                $display("FAIL basic_timeout[%0d]: out_valid=0 after %0d cycles", i, cyc);
                void'(q.pop_front());
                continue;
            end
            e = q.pop_front();
            total++;
            if (cyc + 1 != LAT) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want %0d", i, cyc + 1, LAT);
            end
            total++;
            if (d !== td[i] || borrow_out !== tbo[i] || overflow !== 1'b0) begin
                bad++;
                $display("FAIL basic_const[%0d]: d=%h bo=%0b ov=%0b, want %h/%0b/0", i, d, borrow_out, overflow, td[i], tbo[i]);
            end
            total++;
            if (d !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
                bad++;
                $display("FAIL basic_model[%0d]: d=%h bo=%0b ov=%0b, want %h/%0b/%0b", i, d, borrow_out, overflow, e.d, e.bo, e.ov);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_handoff[%0d]: out_valid=%0b in_ready=%0b, want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] ta [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        logic [N-1:0] tb [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int cyc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], tc[i], 1'b1);
            wait_out(cyc);
            e = q.pop_front();
            total++;
            if (!out_valid || d !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
                bad++;
                $display("FAIL overflow[%0d]: vld=%0b d=%h bo=%0b ov=%0b, want 1/%h/%0b/%0b",
                         i, out_valid, d, borrow_out, overflow, e.d, e.bo, e.ov);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        exp_t e;
        logic [N-1:0] sd;
        logic sbo, sov;
        bit ok = 1'b1;
        out_ready = 1'b0;
        send(32'hCAFE_0123, 32'h1234_5678, 1'b1, 1'b1);
        wait_out(cyc);
        e = q.pop_front();
        total++;
        if (!out_valid || d !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
            bad++;
            $display("FAIL bp_result: vld=%0b d=%h bo=%0b ov=%0b, want 1/%h/%0b/%0b",
                     out_valid, d, borrow_out, overflow, e.d, e.bo, e.ov);
        end
        sd = d; sbo = borrow_out; sov = overflow;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== sd || borrow_out !== sbo || overflow !== sov)
                ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_hold: vld=%0b rdy=%0b d=%h, want 1/0/%h", out_valid, in_ready, d, sd);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== sd) begin
            bad++;
            $display("FAIL bp_release: vld=%0b rdy=%0b d=%h, want 0/1/%h", out_valid, in_ready, d, sd);
        end
    endtask

    task automatic test_isolation();
        int cyc = 0;
        exp_t e;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
        while (!out_valid && cyc < TMO) begin
            a = $urandom; b = $urandom; borrow_in = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; borrow_in = 1'b0;
        e = q.pop_front();
        total++;
        if (!out_valid || d !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
            bad++;
            $display("FAIL isolation: vld=%0b d=%h bo=%0b ov=%0b, want 1/%h/%0b/%0b",
                     out_valid, d, borrow_out, overflow, e.d, e.bo, e.ov);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        exp_t e;
        bit seen = 1'b0;
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: vld=%0b rdy=%0b d=%h bo=%0b ov=%0b, want 0/1/0/0/0",
                     out_valid, in_ready, d, borrow_out, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_mid_ghost: out_valid=1 seen after abandon, want 0");
        end
        send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);
        wait_out(cyc);
        e = q.pop_front();
        total++;
        if (!out_valid || d !== 32'h0000_000F || borrow_out !== 1'b0 || overflow !== e.ov) begin
            bad++;
            $display("FAIL reset_mid_new: vld=%0b d=%h bo=%0b ov=%0b, want 1/0000000f/0/%0b",
                     out_valid, d, borrow_out, overflow, e.ov);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        exp_t e;
        int errs = 0;
        for (int i = 0; i < 10; i++) begin
            send($urandom, $urandom, 1'($urandom), 1'b1);
            wait_out(cyc);
            e = q.pop_front();
            if (!out_valid || cyc + 1 != LAT || d !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
                errs++;
                $display("FAIL b2b[%0d]: lat=%0d d=%h bo=%0b ov=%0b, want %0d/%h/%0b/%0b",
                         i, cyc + 1, d, borrow_out, overflow, LAT, e.d, e.bo, e.ov);
            end
            @(posedge clk); #1;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b_ready[%0d]: in_ready=%0b, want 1", i, in_ready);
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
